// File: rtl/shift_arb_pkg.sv
// Shared constants and types for the shift_rr_arbiter slice.
// The shifter word and amount widths are fixed by the shared shifter instance.
package shift_arb_pkg;

  localparam int SH_DATA_W = 8;
  localparam int SH_K_W    = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Id tag width; a single requester would still need a 1-bit tag.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_rr_arbiter_rr_pick.sv
// Rotate-priority picker: returns the first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_grant
);

  int idx;

  // Walk from the farthest candidate towards ptr so the nearest one wins.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int o = N - 1; o >= 0; o--) begin
      idx = int'(ptr) + o;
      if (idx >= N) idx = idx - N;
      if (req[IW'(idx)]) begin
        grant     = IW'(idx);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_rr_arbiter.sv
// Round-robin front end for one shared 8-bit funnel shifter with a tagged,
// one-entry result register. Optional statistics under SHIFT_ARB_STATS_EN.
//
// state | meaning
// EMPTY | output register holds no result
// FULL  | out_data/out_id valid, waiting for out_ready
module shift_rr_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ),
  parameter int STALL_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*SH_DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*SH_K_W-1:0]     req_k,
  input  logic [NUM_REQ-1:0]            req_left,
  output logic [SH_DATA_W-1:0]          sh_data_in,
  output logic [SH_K_W-1:0]             sh_k,
  output logic                          sh_left,
  input  logic [SH_DATA_W-1:0]          sh_data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SH_DATA_W-1:0]          out_data,
  output logic [ID_W-1:0]               out_id
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STALL_W-1:0]    grant_cnt,
  output logic [STALL_W-1:0]            stall_cnt
`endif
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [SH_DATA_W-1:0]   out_data_q;
  logic [ID_W-1:0]        out_id_q;
  logic [ID_W-1:0]        grant, sel;
  logic                   any_grant, can_accept, accept;

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // rst_n gating keeps req_ready low for the whole reset window.
  assign can_accept = rst_n & ((state_q == EMPTY) | out_ready);
  assign accept     = can_accept & any_grant;
  assign sel        = any_grant ? grant : ptr_q;
  assign ptr_d      = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    if (accept) req_ready[grant] = 1'b1;
    sh_data_in = req_data[sel*SH_DATA_W +: SH_DATA_W];
    sh_k       = req_k[sel*SH_K_W +: SH_K_W];
    sh_left    = req_left[sel];
    out_valid  = (state_q == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
    end else if (accept) begin
      ptr_q      <= ptr_d;
      out_data_q <= sh_data_out;
      out_id_q   <= grant;
    end
  end

  assign out_data = out_data_q;
  assign out_id   = out_id_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [NUM_REQ-1:0][STALL_W-1:0] gcnt_q;
  logic [STALL_W-1:0]              stall_q;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && grant == ID_W'(i) && !(&gcnt_q[i]))
          gcnt_q[i] <= gcnt_q[i] + 1'b1;
      end
      if (state_q == FULL && !out_ready && !(&stall_q))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign grant_cnt = gcnt_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_shift_rr_arbiter.sv
// Self-checking bench for shift_rr_arbiter: directed scenarios plus a random
// phase, all checked against a transaction-level model of the arbiter.
module tb_shift_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int STALL_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*8-1:0]   req_data;
  logic [NUM_REQ*3-1:0]   req_k;
  logic [NUM_REQ-1:0]     req_left;
  logic [7:0]             sh_data_in;
  logic [2:0]             sh_k;
  logic                   sh_left;
  logic [7:0]             sh_data_out;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_data;
  logic [ID_W-1:0]        out_id;
`ifdef SHIFT_ARB_STATS_EN
  logic [NUM_REQ*STALL_W-1:0] grant_cnt;
  logic [STALL_W-1:0]         stall_cnt;
`endif

  shift_rr_arbiter #(.NUM_REQ(NUM_REQ), .STALL_W(STALL_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_k       (req_k),
    .req_left    (req_left),
    .sh_data_in  (sh_data_in),
    .sh_k        (sh_k),
    .sh_left     (sh_left),
    .sh_data_out (sh_data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the shared shifter instance.
  assign sh_data_out = sh_left ? (sh_data_in << sh_k) : (sh_data_in >> sh_k);

  int checks = 0;
  int errors = 0;

  // Requester-side view.
  bit         v [NUM_REQ];
  logic [7:0] d [NUM_REQ];
  int         k [NUM_REQ];
  bit         l [NUM_REQ];

  // Model of the result register and rotation pointer.
  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_id;
  bit         last_acc;
  int         last_g;

  function automatic logic [7:0] ref_shift(input logic [7:0] x, input int kk, input bit left);
    int val;
    val = int'(x);
    if (left) return 8'((val * (2 ** kk)) % 256);
    return 8'(val / (2 ** kk));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]       = v[i];
      req_data[8*i +: 8] = d[i];
      req_k[3*i +: 3]    = 3'(k[i]);
      req_left[i]        = l[i];
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] dd, input int kk, input bit ll);
    v[i] = 1'b1; d[i] = dd; k[i] = kk; l[i] = ll;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_id = 0; last_acc = 1'b0;
  endtask

  // One clock: check the present cycle against the model, then advance it.
  task automatic step();
    int  g;
    bit  any, ca;
    logic [NUM_REQ-1:0] exp_rdy;
    drive();
    #1;
    any = 1'b0; g = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      int idx;
      idx = (m_ptr + o) % NUM_REQ;
      if (!any && v[idx]) begin any = 1'b1; g = idx; end
    end
    ca = !m_valid || out_ready;
    exp_rdy = (any && ca) ? NUM_REQ'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_id", 32'(out_id), 32'(m_id));
    end
    if (any) begin
      check("sh_data_in", 32'(sh_data_in), 32'(d[g]));
      check("sh_k", 32'(sh_k), 32'(k[g]));
      check("sh_left", 32'(sh_left), 32'(l[g]));
    end else begin
      check("sh_data_in_idle", 32'(sh_data_in), 32'(d[m_ptr]));
    end
    @(posedge clk);
    last_acc = any && ca;
    if (any && ca) begin
      m_valid = 1'b1;
      m_data  = ref_shift(d[g], k[g], l[g]);
      m_id    = g;
      m_ptr   = (g + 1) % NUM_REQ;
      last_g  = g;
      v[g]    = 1'b0;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) v[i] = 1'b0;
    drive();
    model_reset();
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int ids[$];
    logic [7:0] held_d;
    logic [ID_W-1:0] held_id;

    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = 1'b0; d[i] = 8'(i * 17); k[i] = i % 8; l[i] = i[0];
    end
    out_ready = 1'b1;
    drive();
    model_reset();
    @(posedge clk); #1;
    do_reset();
    @(posedge clk); #1;

    // Single SLL request.
    set_req(0, 8'hB5, 3, 1'b1);
    step();
    check("sll_data", 32'(out_data), 32'h0000_00A8);
    check("sll_id", 32'(out_id), 32'd0);
    check("sll_valid", 32'(out_valid), 32'd1);
    step();
    check("sll_valid_drop", 32'(out_valid), 32'd0);

    // SRL and k=0 pass-through.
    set_req(2, 8'hB5, 3, 1'b0);
    step();
    check("srl_data", 32'(out_data), 32'h0000_0016);
    check("srl_id", 32'(out_id), 32'd2);
    set_req(2, 8'h81, 0, 1'b1);
    step();
    check("k0_data", 32'(out_data), 32'h0000_0081);
    step();

    // Round robin with every requester permanently valid.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'($urandom), int'($urandom_range(7)), 1'($urandom));
    for (int c = 0; c < 6; c++) begin
      step();
      ids.push_back(int'(out_id));
      check("rr_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < NUM_REQ; i++)
        if (!v[i]) set_req(i, 8'($urandom), int'($urandom_range(7)), 1'($urandom));
    end
    for (int c = 0; c < 6; c++) check("rr_order", 32'(ids[c]), 32'(c % NUM_REQ));

    // Backpressure for three cycles while FULL.
    held_d  = out_data;
    held_id = out_id;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_data", 32'(out_data), 32'(held_d));
      check("bp_hold_id", 32'(out_id), 32'(held_id));
    end
    out_ready = 1'b1;
    step();
    check("bp_next_grant", 32'(out_id), 32'((int'(held_id) + 1) % NUM_REQ));

    // Async reset in the middle of a cycle while FULL.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'($urandom), int'($urandom_range(7)), 1'($urandom));
    step();
    check("arst_first_id", 32'(out_id), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) v[i] = 1'b0;
    step();

    // Random traffic; a pending request stays stable until accepted.
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < NUM_REQ; i++)
        if (!v[i] && $urandom_range(1) == 1)
          set_req(i, 8'($urandom), int'($urandom_range(7)), 1'($urandom));
      step();
    end

`ifdef SHIFT_ARB_STATS_EN
    do_reset();
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_req(1, 8'($urandom), int'($urandom_range(7)), 1'($urandom));
      step();
    end
    out_ready = 1'b0;
    step();
    step();
    check("grant_cnt1", 32'(grant_cnt[1*STALL_W +: STALL_W]), 32'd5);
    check("grant_cnt0", 32'(grant_cnt[0*STALL_W +: STALL_W]), 32'd0);
    check("stall_cnt", 32'(stall_cnt), 32'd2);
    for (int c = 0; c < (1 << STALL_W); c++) @(posedge clk);
    #1;
    check("stall_sat", 32'(stall_cnt), 32'(16'hFFFF));
    out_ready = 1'b1;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
